// File: rtl/m_ll_queue_ctrl_if.sv
// Handshake bundle between the linked-list queue controller, its push/pop streams and the
// paired free list. The slave modport is the controller's view.
interface m_ll_queue_ctrl_if #(
  parameter int unsigned EN      = 7,
  parameter int unsigned DW      = 8,
  parameter int unsigned CNT_WDT = $clog2(EN + 1)
);
  logic               flush;
  logic               push_vld;
  logic               push_rdy;
  logic [DW-1:0]      push_data;
  logic               pop_vld;
  logic               pop_rdy;
  logic [DW-1:0]      pop_data;
  logic               fl_vld;
  logic               fl_rdy;
  logic [EN-1:0]      fl;
  logic               ret_vld;
  logic               ret_rdy;
  logic [EN-1:0]      ret;
  logic               flush_fl;
  logic [CNT_WDT-1:0] cnt;

  modport slave (
    input  flush, push_vld, push_data, pop_rdy, fl_vld, fl, ret_rdy,
    output push_rdy, pop_vld, pop_data, fl_rdy, ret_vld, ret, flush_fl, cnt
  );

  modport master (
    output flush, push_vld, push_data, pop_rdy, fl_vld, fl, ret_rdy,
    input  push_rdy, pop_vld, pop_data, fl_rdy, ret_vld, ret, flush_fl, cnt
  );
endinterface

// File: rtl/m_ll_queue_ctrl.sv
// Linked-list FIFO controller: entries come one-hot from a free list on push, are chained through
// a next-pointer array, and go back to the free list as they are popped from the head.
module m_ll_queue_ctrl #(
  parameter int unsigned EN      = 7,
  parameter int unsigned DW      = 8,
  parameter int unsigned L2_EN   = $clog2(EN),
  parameter int unsigned CNT_WDT = $clog2(EN + 1)
) (
  input  logic                   clk,
  input  logic                   rst_n,
  m_ll_queue_ctrl_if.slave       bus
);

  logic [DW-1:0]      r_mem  [EN];
  logic [L2_EN-1:0]   r_next [EN];
  logic [L2_EN-1:0]   r_head;
  logic [L2_EN-1:0]   r_tail;
  logic [CNT_WDT-1:0] r_cnt;

  logic [L2_EN-1:0]   w_head_d;
  logic [L2_EN-1:0]   w_tail_d;
  logic [CNT_WDT-1:0] w_cnt_d;
  logic [CNT_WDT-1:0] w_cnt_after_pop;
  logic [L2_EN-1:0]   w_push_idx;
  logic               w_push_rdy;
  logic               w_pop_vld;
  logic               w_push;
  logic               w_pop;

  function automatic logic [L2_EN-1:0] f_onehot2idx(input logic [EN-1:0] oh);
    logic [L2_EN-1:0] idx;
    idx = '0;
    for (int i = 0; i < int'(EN); i++) begin
      if (oh[i]) idx |= L2_EN'(i);
    end
    return idx;
  endfunction

  function automatic logic [EN-1:0] f_idx2onehot(input logic [L2_EN-1:0] idx);
    return EN'(1) << idx;
  endfunction

  // Reset gates the ready/valid outputs so no handshake can complete while rst_n is low.
  assign w_push_rdy = bus.fl_vld & ~bus.flush & rst_n;
  assign w_pop_vld  = (r_cnt != '0) & bus.ret_rdy & ~bus.flush;
  assign w_push     = bus.push_vld & w_push_rdy;
  assign w_pop      = w_pop_vld & bus.pop_rdy;
  assign w_push_idx = f_onehot2idx(bus.fl);

  assign w_cnt_after_pop = r_cnt - CNT_WDT'(w_pop);

  assign bus.push_rdy = w_push_rdy;
  assign bus.fl_rdy   = w_push;
  assign bus.pop_vld  = w_pop_vld;
  assign bus.pop_data = r_mem[r_head];
  assign bus.ret_vld  = w_pop;
  assign bus.ret      = w_pop ? f_idx2onehot(r_head) : '0;
  assign bus.flush_fl = bus.flush & rst_n;
  assign bus.cnt      = r_cnt;

  always_comb begin
    w_head_d = r_head;
    w_tail_d = r_tail;
    w_cnt_d  = r_cnt;
    if (bus.flush) begin
      w_head_d = '0;
      w_tail_d = '0;
      w_cnt_d  = '0;
    end else begin
      if (w_pop) w_head_d = r_next[r_head];
      // A push into a queue that is (or just became) empty starts a new chain.
      if (w_push) begin
        w_tail_d = w_push_idx;
        if (w_cnt_after_pop == '0) w_head_d = w_push_idx;
      end
      w_cnt_d = w_cnt_after_pop + CNT_WDT'(w_push);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_head <= '0;
      r_tail <= '0;
      r_cnt  <= '0;
    end else begin
      r_head <= w_head_d;
      r_tail <= w_tail_d;
      r_cnt  <= w_cnt_d;
    end
  end

  // Payload and link storage carry no reset; only entries reachable from head are ever read.
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem[w_push_idx] <= bus.push_data;
      if (w_cnt_after_pop != '0) r_next[r_tail] <= w_push_idx;
    end
  end

endmodule

// File: tb/tb_m_ll_queue_ctrl.sv
// Directed bench for m_ll_queue_ctrl with a small behavioural free list (lowest free entry first).
module tb_m_ll_queue_ctrl;
  localparam int unsigned EN = 7;
  localparam int unsigned DW = 8;

  logic clk;
  logic rst_n;
  int   checks;
  int   failures;

  m_ll_queue_ctrl_if #(.EN(EN), .DW(DW)) u_if ();

  m_ll_queue_ctrl #(.EN(EN), .DW(DW)) u_dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (u_if)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Free-list stand-in: hands out the lowest free entry, takes returns, refills on flush_fl.
  logic [EN-1:0] r_free;
  logic [EN-1:0] w_free_d;
  logic [EN-1:0] w_fl_sel;

  always_comb begin
    w_fl_sel = '0;
    for (int i = EN - 1; i >= 0; i--) begin
      if (r_free[i]) w_fl_sel = EN'(1) << i;
    end
  end

  always_comb begin
    w_free_d = r_free;
    if (u_if.fl_vld && u_if.fl_rdy) w_free_d = w_free_d & ~u_if.fl;
    if (u_if.ret_vld && u_if.ret_rdy) w_free_d = w_free_d | u_if.ret;
    if (u_if.flush_fl) w_free_d = '1;
  end

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_free <= '1;
    else        r_free <= w_free_d;
  end

  assign u_if.fl_vld = |r_free;
  assign u_if.fl     = w_fl_sel;

  always @(negedge clk) begin
    if (rst_n && u_if.fl_vld && !$onehot(u_if.fl)) begin
      failures++;
      $display("FAIL fl_onehot got=%b required one-hot", u_if.fl);
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic sample();
    @(negedge clk);
  endtask

  task automatic idle();
    u_if.push_vld  = 1'b0;
    u_if.pop_rdy   = 1'b0;
    u_if.flush     = 1'b0;
    u_if.push_data = '0;
  endtask

  task automatic push_one(input logic [DW-1:0] d);
    idle();
    u_if.push_vld  = 1'b1;
    u_if.push_data = d;
    step();
    idle();
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    u_if.push_vld = 1'b1;
    u_if.pop_rdy  = 1'b1;
    u_if.flush    = 1'b1;
    sample();
    checks++;
    if (u_if.push_rdy !== 1'b0 || u_if.fl_rdy !== 1'b0) begin
      failures++;
      $display("FAIL reset_push got rdy=%b fl_rdy=%b required 0 0", u_if.push_rdy, u_if.fl_rdy);
    end
    checks++;
    if (u_if.pop_vld !== 1'b0 || u_if.ret_vld !== 1'b0 || u_if.flush_fl !== 1'b0) begin
      failures++;
      $display("FAIL reset_pop got pop_vld=%b ret_vld=%b flush_fl=%b required 0 0 0",
               u_if.pop_vld, u_if.ret_vld, u_if.flush_fl);
    end
    checks++;
    if (u_if.cnt !== 3'd0) begin
      failures++;
      $display("FAIL reset_cnt got=%0d required=0", u_if.cnt);
    end
    step();
    rst_n = 1'b1;
    idle();
    step();
  endtask

  task automatic test_basic();
    logic [EN-1:0] exp_oh;
    logic [DW-1:0] exp_d;
    for (int i = 0; i < 3; i++) begin
      exp_oh = EN'(1) << i;
      exp_d  = DW'(8'h11 * (i + 1));
      u_if.push_vld  = 1'b1;
      u_if.push_data = exp_d;
      sample();
      checks++;
      if (u_if.fl !== exp_oh || u_if.fl_rdy !== 1'b1) begin
        failures++;
        $display("FAIL basic_push%0d got fl=%b fl_rdy=%b required fl=%b fl_rdy=1",
                 i, u_if.fl, u_if.fl_rdy, exp_oh);
      end
      step();
    end
    idle();
    sample();
    checks++;
    if (u_if.cnt !== 3'd3 || u_if.pop_vld !== 1'b1) begin
      failures++;
      $display("FAIL basic_cnt got cnt=%0d pop_vld=%b required 3 1", u_if.cnt, u_if.pop_vld);
    end
    step();
    for (int i = 0; i < 3; i++) begin
      exp_oh = EN'(1) << i;
      exp_d  = DW'(8'h11 * (i + 1));
      u_if.pop_rdy = 1'b1;
      sample();
      checks++;
      if (u_if.pop_data !== exp_d || u_if.ret !== exp_oh || u_if.ret_vld !== 1'b1) begin
        failures++;
        $display("FAIL basic_pop%0d got data=%h ret=%b ret_vld=%b required %h %b 1",
                 i, u_if.pop_data, u_if.ret, u_if.ret_vld, exp_d, exp_oh);
      end
      step();
    end
    idle();
    sample();
    checks++;
    if (u_if.cnt !== 3'd0 || u_if.pop_vld !== 1'b0 || u_if.ret_vld !== 1'b0) begin
      failures++;
      $display("FAIL basic_empty got cnt=%0d pop_vld=%b ret_vld=%b required 0 0 0",
               u_if.cnt, u_if.pop_vld, u_if.ret_vld);
    end
    step();
  endtask

  task automatic test_latency();
    u_if.push_vld  = 1'b1;
    u_if.push_data = 8'hA5;
    u_if.pop_rdy   = 1'b1;
    sample();
    checks++;
    if (u_if.pop_vld !== 1'b0) begin
      failures++;
      $display("FAIL latency_same_cycle got pop_vld=%b required 0", u_if.pop_vld);
    end
    step();
    idle();
    u_if.pop_rdy = 1'b1;
    sample();
    checks++;
    if (u_if.pop_vld !== 1'b1 || u_if.pop_data !== 8'hA5) begin
      failures++;
      $display("FAIL latency_next got pop_vld=%b data=%h required 1 a5",
               u_if.pop_vld, u_if.pop_data);
    end
    step();
    idle();
    step();
  endtask

  task automatic test_simul();
    push_one(8'h01);
    u_if.push_vld  = 1'b1;
    u_if.push_data = 8'h02;
    u_if.pop_rdy   = 1'b1;
    sample();
    checks++;
    if (u_if.pop_data !== 8'h01 || u_if.ret !== 7'b0000001 || u_if.fl !== 7'b0000010) begin
      failures++;
      $display("FAIL simul_pop got data=%h ret=%b fl=%b required 01 0000001 0000010",
               u_if.pop_data, u_if.ret, u_if.fl);
    end
    step();
    idle();
    sample();
    checks++;
    if (u_if.cnt !== 3'd1 || u_if.pop_vld !== 1'b1 || u_if.pop_data !== 8'h02) begin
      failures++;
      $display("FAIL simul_after got cnt=%0d pop_vld=%b data=%h required 1 1 02",
               u_if.cnt, u_if.pop_vld, u_if.pop_data);
    end
    step();
    u_if.pop_rdy = 1'b1;
    sample();
    checks++;
    if (u_if.ret !== 7'b0000010) begin
      failures++;
      $display("FAIL simul_ret got=%b required=0000010", u_if.ret);
    end
    step();
    idle();
    step();
  endtask

  task automatic test_full();
    logic [EN-1:0] exp_oh;
    for (int i = 0; i < int'(EN); i++) push_one(DW'(8'h40 + i));
    u_if.push_vld  = 1'b1;
    u_if.push_data = 8'hEE;
    sample();
    checks++;
    if (u_if.push_rdy !== 1'b0 || u_if.cnt !== 3'd7) begin
      failures++;
      $display("FAIL full_stall got push_rdy=%b cnt=%0d required 0 7", u_if.push_rdy, u_if.cnt);
    end
    step();
    u_if.pop_rdy = 1'b1;
    sample();
    checks++;
    if (u_if.ret_vld !== 1'b1 || u_if.ret !== 7'b0000001 || u_if.pop_data !== 8'h40) begin
      failures++;
      $display("FAIL full_pop got ret_vld=%b ret=%b data=%h required 1 0000001 40",
               u_if.ret_vld, u_if.ret, u_if.pop_data);
    end
    step();
    u_if.pop_rdy   = 1'b0;
    u_if.push_data = 8'h47;
    sample();
    checks++;
    if (u_if.push_rdy !== 1'b1 || u_if.fl !== 7'b0000001) begin
      failures++;
      $display("FAIL full_refill got push_rdy=%b fl=%b required 1 0000001",
               u_if.push_rdy, u_if.fl);
    end
    step();
    idle();
    for (int k = 0; k < int'(EN); k++) begin
      exp_oh = EN'(1) << ((k + 1) % EN);
      u_if.pop_rdy = 1'b1;
      sample();
      checks++;
      if (u_if.pop_data !== DW'(8'h41 + k) || u_if.ret !== exp_oh) begin
        failures++;
        $display("FAIL full_drain%0d got data=%h ret=%b required %h %b",
                 k, u_if.pop_data, u_if.ret, DW'(8'h41 + k), exp_oh);
      end
      step();
    end
    idle();
    step();
  endtask

  task automatic test_backpressure();
    push_one(8'h61);
    push_one(8'h62);
    u_if.ret_rdy = 1'b0;
    for (int i = 0; i < 3; i++) begin
      u_if.pop_rdy = 1'b1;
      sample();
      checks++;
      if (u_if.pop_vld !== 1'b0 || u_if.ret_vld !== 1'b0 || u_if.cnt !== 3'd2) begin
        failures++;
        $display("FAIL bp_hold%0d got pop_vld=%b ret_vld=%b cnt=%0d required 0 0 2",
                 i, u_if.pop_vld, u_if.ret_vld, u_if.cnt);
      end
      step();
    end
    u_if.ret_rdy = 1'b1;
    for (int i = 0; i < 2; i++) begin
      sample();
      checks++;
      if (u_if.pop_vld !== 1'b1 || u_if.pop_data !== DW'(8'h61 + i)) begin
        failures++;
        $display("FAIL bp_resume%0d got pop_vld=%b data=%h required 1 %h",
                 i, u_if.pop_vld, u_if.pop_data, DW'(8'h61 + i));
      end
      step();
    end
    idle();
    step();
  endtask

  task automatic test_flush();
    for (int i = 0; i < 4; i++) push_one(DW'(8'h71 + i));
    u_if.flush    = 1'b1;
    u_if.push_vld = 1'b1;
    u_if.pop_rdy  = 1'b1;
    sample();
    checks++;
    if (u_if.flush_fl !== 1'b1 || u_if.push_rdy !== 1'b0 || u_if.pop_vld !== 1'b0
        || u_if.cnt !== 3'd4) begin
      failures++;
      $display("FAIL flush_cycle got flush_fl=%b push_rdy=%b pop_vld=%b cnt=%0d required 1 0 0 4",
               u_if.flush_fl, u_if.push_rdy, u_if.pop_vld, u_if.cnt);
    end
    step();
    idle();
    sample();
    checks++;
    if (u_if.cnt !== 3'd0 || u_if.pop_vld !== 1'b0 || r_free !== 7'h7f) begin
      failures++;
      $display("FAIL flush_after got cnt=%0d pop_vld=%b free=%b required 0 0 1111111",
               u_if.cnt, u_if.pop_vld, r_free);
    end
    step();
    u_if.push_vld  = 1'b1;
    u_if.push_data = 8'h5A;
    sample();
    checks++;
    if (u_if.fl !== 7'b0000001 || u_if.fl_rdy !== 1'b1) begin
      failures++;
      $display("FAIL flush_push got fl=%b fl_rdy=%b required 0000001 1", u_if.fl, u_if.fl_rdy);
    end
    step();
    idle();
    u_if.pop_rdy = 1'b1;
    sample();
    checks++;
    if (u_if.pop_vld !== 1'b1 || u_if.pop_data !== 8'h5A || u_if.ret !== 7'b0000001) begin
      failures++;
      $display("FAIL flush_pop got pop_vld=%b data=%h ret=%b required 1 5a 0000001",
               u_if.pop_vld, u_if.pop_data, u_if.ret);
    end
    step();
    idle();
    step();
  endtask

  task automatic test_async_reset();
    push_one(8'h81);
    push_one(8'h82);
    u_if.push_vld  = 1'b1;
    u_if.push_data = 8'h83;
    rst_n = 1'b0;
    #1;
    checks++;
    if (u_if.cnt !== 3'd0 || u_if.pop_vld !== 1'b0 || u_if.push_rdy !== 1'b0
        || u_if.fl_rdy !== 1'b0) begin
      failures++;
      $display("FAIL areset got cnt=%0d pop_vld=%b push_rdy=%b fl_rdy=%b required 0 0 0 0",
               u_if.cnt, u_if.pop_vld, u_if.push_rdy, u_if.fl_rdy);
    end
    step();
    rst_n = 1'b1;
    idle();
    sample();
    checks++;
    if (u_if.cnt !== 3'd0 || r_free !== 7'h7f) begin
      failures++;
      $display("FAIL areset_after got cnt=%0d free=%b required 0 1111111", u_if.cnt, r_free);
    end
    step();
  endtask

  initial begin
    checks       = 0;
    failures     = 0;
    rst_n        = 1'b0;
    u_if.ret_rdy = 1'b1;
    idle();
    test_reset();
    test_basic();
    test_latency();
    test_simul();
    test_full();
    test_backpressure();
    test_flush();
    test_async_reset();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout got=running required=finished");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/m_ll_queue_ctrl.md
Name: m_ll_queue_ctrl

Overview:
- Linked-list FIFO controller that sits on the consumer side of m_free_list_ff.
- It takes one-hot free entries from the free list on each push, links them into a singly linked queue, and returns each entry to the free list on pop.
- Data and next-pointers live in internal flop arrays indexed by entry.
- The controller drives fl_rdy, ret_vld, ret and flush_fl toward the free list; its own upstream and downstream are push and pop vld/rdy streams.

Parameters:
- EN, 7, number of entries; must match the paired free list.
- DW, 8, payload width.
- L2_EN, $clog2(EN), index width (derived).
- CNT_WDT, $clog2(EN+1), occupancy counter width (derived).

Ports:
- clk  input  1  clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- flush  input  1  synchronous queue clear.
- push_vld  input  1  push request.
- push_rdy  output  1  push accepted when high with push_vld.
- push_data  input  DW  payload.
- pop_vld  output  1  head entry available.
- pop_rdy  input  1  consumer takes head.
- pop_data  output  DW  payload at head.
- fl_vld  input  1  free list has an entry.
- fl_rdy  output  1  take free entry.
- fl  input  EN  one-hot free entry.
- ret_vld  output  1  returning an entry.
- ret_rdy  input  1  free list accepts return.
- ret  output  EN  one-hot returned entry.
- flush_fl  output  1  flush forwarded to the free list.
- cnt  output  CNT_WDT  entries currently queued.

Behaviour:
- Reset (rst_n=0, async): head=0, tail=0, cnt=0, pop_vld=0, ret_vld=0, fl_rdy=0, flush_fl=0, push_rdy=0.
- Data and next arrays are not reset.
- push_rdy = fl_vld & ~flush. fl_rdy = push_vld & push_rdy.
- A push fires when push_vld & push_rdy.
- On push, idx = onehot2idx(fl):
  - mem[idx] <= push_data.
  - If cnt != 0 (after any pop in the same cycle), next[tail] <= idx.
  - tail <= idx.
  - If the queue is empty, or becomes empty through a simultaneous pop, head <= idx.
- pop_vld = (cnt != 0) & ret_rdy & ~flush. pop_data = mem[head], combinational read.
- A pop fires when pop_vld & pop_rdy.
- On pop:
  - ret_vld = 1 and ret = idx2onehot(head), both combinational in the same cycle.
  - head <= next[head].
- ret_vld is never high without a pop. ret_vld is always 0 when cnt=0.
- Latency:
  - A pushed entry is visible on pop_vld/pop_data the cycle after its push.
  - There is no push-to-pop bypass in the same cycle.
- Simultaneous push and pop:
  - cnt is unchanged.
  - When cnt=1, head <= the new idx and tail <= the new idx. The stale next[] write is ignored.
- cnt rules:
  - cnt += 1 on push only.
  - cnt -= 1 on pop only.
  - cnt can never exceed EN, because push_rdy follows fl_vld.
  - cnt can never underflow, because pop_vld is gated by cnt != 0.
- Full (cnt=EN): fl_vld is 0 from the free list, so push_rdy=0 and the push stalls.
- Empty: pop_vld=0, and pop_data is don't-care.
- Free list backpressure: when ret_rdy=0, pop_vld=0 and the head is held.
- flush:
  - flush_fl = flush, combinational.
  - Next cycle: head=0, tail=0, cnt=0.
  - push_rdy and pop_vld are forced to 0 during flush.
  - Entries are not returned one by one; the free list refills itself on flush_fl.
- Indices:
  - onehot2idx is an OR-reduction of bit positions.
  - Non-one-hot fl while fl_vld=1 is illegal. The bench flags it; the RTL behaviour is undefined.
- Reset asserted mid-operation: all state clears immediately. Any handshake in that cycle is void.

Test Plan:
- After reset, push 0x11, 0x22, 0x33 with fl=7'b0000001, 7'b0000010, 7'b0000100 -> cnt=3. Popping returns 0x11, 0x22, 0x33 in order, with ret = 7'b0000001, 7'b0000010, 7'b0000100, one per cycle.
- Push 0xA5 into an empty queue -> pop_vld=0 in the push cycle, pop_vld=1 with pop_data=0xA5 the next cycle.
- With cnt=1 (head data 0x01), push 0x02 and pop in the same cycle -> pop_data=0x01, ret = head one-hot, cnt stays 1, and the next pop_data is 0x02.
- Fill to 7 entries until fl_vld=0 -> push_rdy=0 and cnt=7. One pop -> ret_vld=1, fl_vld returns from the free list, and the next push is accepted.
- With cnt=2, hold ret_rdy=0 and pop_rdy=1 for 3 cycles -> pop_vld=0, ret_vld=0, cnt=2. Release ret_rdy -> pops resume in order.
- With cnt=4, pulse flush for 1 cycle -> flush_fl=1 that cycle, cnt=0 next cycle, pop_vld=0. The free list reports used=0, and a subsequent push/pop of 0x5A works.
